// File: rtl/iterative_multiplier_pkg.sv
// iterative_multiplier_pkg: shared types and core-wide defaults for the RV32M multiplier.
package iterative_multiplier_pkg;
    localparam int WORD_W = 32;
    localparam int MULT_BPC = 4;
    typedef enum logic [1:0] {MUL, MULH, MULHSU, MULHU} mult_op_t;
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mult_state_t;
endpackage

// File: rtl/iterative_multiplier.sv
// iterative_multiplier: multi-cycle shift-add RV32M multiplier feeding the mult_ready stall handshake.
module iterative_multiplier
    import iterative_multiplier_pkg::*;
#(
    parameter int W = WORD_W,
    parameter int BPC = MULT_BPC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mult,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         advance,
    input  logic         flush,
    output logic [W-1:0] result,
    output logic         mult_ready
);
    localparam int N = W / BPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    mult_state_t    r_state, w_state_nxt;
    mult_op_t       r_op, w_op;
    logic           r_neg;
    logic [2*W-1:0] r_ma, r_acc;
    logic [W-1:0]   r_mb, r_result;
    logic [CW-1:0]  r_cnt;
    logic           w_sa, w_sb, w_accept, w_finish;
    logic [W-1:0]   w_abs_a, w_abs_b;
    logic [2*W-1:0] w_pp, w_sum, w_prod;

    // Magnitudes make every op an unsigned product; sign is restored once at the end.
    always_comb begin
        w_op = mult_op_t'(op);
        w_sa = a[W-1] & (w_op == MULH || w_op == MULHSU);
        w_sb = b[W-1] & (w_op == MULH);
        w_abs_a = w_sa ? -a : a;
        w_abs_b = w_sb ? -b : b;
        w_pp = r_ma * {{(2*W-BPC){1'b0}}, r_mb[BPC-1:0]};
        w_sum = r_acc + w_pp;
        w_prod = r_neg ? -w_sum : w_sum;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (mult) w_state_nxt = S_BUSY;
            S_BUSY: if (!mult) w_state_nxt = S_IDLE; else if (r_cnt == '0) w_state_nxt = S_DONE;
            S_DONE: if (advance) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) w_state_nxt = S_IDLE;
        w_accept = (r_state == S_IDLE) && (w_state_nxt == S_BUSY);
        w_finish = (r_state == S_BUSY) && (w_state_nxt == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else r_state <= w_state_nxt;
    end

    // The multiplicand shifts left instead of using a variable shifter on each partial product.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op <= MUL;
            r_neg <= 1'b0;
            r_ma <= '0;
            r_mb <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op <= w_op;
            r_neg <= w_sa ^ w_sb;
            r_ma <= {{W{1'b0}}, w_abs_a};
            r_mb <= w_abs_b;
            r_acc <= '0;
            r_cnt <= CW'(N - 1);
        end else if (r_state == S_BUSY) begin
            r_acc <= w_sum;
            r_ma <= r_ma << BPC;
            r_mb <= r_mb >> BPC;
            r_cnt <= r_cnt - 1'b1;
            if (w_finish) r_result <= (r_op == MUL) ? w_prod[W-1:0] : w_prod[2*W-1:W];
        end
    end

    assign result = r_result;
    assign mult_ready = (r_state == S_DONE);
endmodule

// File: tb/tb_iterative_multiplier.sv
// tb_iterative_multiplier: directed and randomized checks of iterative_multiplier for BPC in {1,2,4,8}.
module tb_iterative_multiplier;
    import iterative_multiplier_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mlt[4], adv[4], fls[4], rdy[4];
    logic [1:0]  opv[4];
    logic [31:0] av[4], bv[4], res[4];
    int          n_chk = 0;
    int          n_err = 0;
    vec_t        vt[10];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : gen_dut
        iterative_multiplier #(.W(32), .BPC(1 << g)) u_dut (
            .clk(clk), .rst(rst), .mult(mlt[g]), .op(opv[g]), .a(av[g]), .b(bv[g]),
            .advance(adv[g]), .flush(fls[g]), .result(res[g]), .mult_ready(rdy[g])
        );
    end

    function automatic logic [31:0] ref_mul(logic [1:0] o, logic [31:0] x, logic [31:0] y);
        logic signed [65:0] sx, sy, p;
        sx = {{34{x[31] & (o == 2'd1 || o == 2'd2)}}, x};
        sy = {{34{y[31] & (o == 2'd1)}}, y};
        p = sx * sy;
        return (o == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic start(int g, logic [1:0] o, logic [31:0] x, logic [31:0] y);
        mlt[g] = 1'b1;
        opv[g] = o;
        av[g] = x;
        bv[g] = y;
    endtask

    // Scrambles operands after the accepting edge; the DUT must ignore them.
    task automatic run_to_ready(int g, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
            av[g] = $urandom;
            bv[g] = $urandom;
            opv[g] = 2'($urandom);
        end while (!rdy[g] && lat < 200);
    endtask

    task automatic idle_watch(int g, int cycles, string nm);
        logic seen;
        seen = 1'b0;
        repeat (cycles) begin
            tick();
            seen |= rdy[g];
        end
        chk(nm, {31'b0, seen}, 32'd0);
    endtask

    task automatic run_random(int g, int ops);
        int lat, nn;
        logic fl;
        logic [31:0] x, y, e;
        logic [1:0] o;
        nn = 32 / (1 << g);
        for (int i = 0; i < ops; i++) begin
            o = 2'($urandom);
            x = pick();
            y = pick();
            e = ref_mul(o, x, y);
            start(g, o, x, y);
            lat = 0;
            fl = 1'b0;
            while (!fl && !rdy[g] && lat < 200) begin
                if ($urandom_range(0, 149) == 0) fls[g] = 1'b1;
                tick();
                lat++;
                av[g] = $urandom;
                bv[g] = $urandom;
                opv[g] = 2'($urandom);
                if (fls[g]) begin
                    fls[g] = 1'b0;
                    mlt[g] = 1'b0;
                    fl = 1'b1;
                    chk("rnd_flush_rdy", {31'b0, rdy[g]}, 32'd0);
                end
            end
            if (!fl) begin
                chk("rnd_latency", lat, nn + 1);
                chk("rnd_result", res[g], e);
                repeat ($urandom_range(0, 3)) begin
                    tick();
                    chk("rnd_hold", {rdy[g], res[g][30:0]}, {1'b1, e[30:0]});
                end
                adv[g] = 1'b1;
                fls[g] = ($urandom_range(0, 9) == 0);
                mlt[g] = 1'b0;
                tick();
                adv[g] = 1'b0;
                fls[g] = 1'b0;
                chk("rnd_adv_rdy", {31'b0, rdy[g]}, 32'd0);
            end
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    initial begin
        int lat;
        logic [31:0] last;
        vt[0] = '{2'd0, 32'd7, 32'd6, 32'd42};
        vt[1] = '{2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vt[2] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h0};
        vt[3] = '{2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vt[4] = '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vt[5] = '{2'd0, 32'd3, 32'd5, 32'd15};
        vt[6] = '{2'd0, 32'h0001_0000, 32'h0001_0000, 32'h0};
        vt[7] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vt[8] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
        vt[9] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1};
        rst = 1'b1;
        for (int g = 0; g < 4; g++) begin
            mlt[g] = 1'b0; adv[g] = 1'b0; fls[g] = 1'b0;
            opv[g] = 2'd0; av[g] = '0; bv[g] = '0;
        end
        repeat (2) tick();
        chk("reset_result", res[2], 32'd0);
        chk("reset_ready", {31'b0, rdy[2]}, 32'd0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            start(2, vt[i].op, vt[i].a, vt[i].b);
            run_to_ready(2, lat);
            chk($sformatf("vec%0d_latency", i), lat, 32'd9);
            chk($sformatf("vec%0d_result", i), res[2], vt[i].exp);
            repeat (2) begin
                tick();
                chk($sformatf("vec%0d_hold_rdy", i), {31'b0, rdy[2]}, 32'd1);
                chk($sformatf("vec%0d_hold_res", i), res[2], vt[i].exp);
            end
            mlt[2] = 1'b0;
            adv[2] = 1'b1;
            tick();
            adv[2] = 1'b0;
            chk($sformatf("vec%0d_adv_rdy", i), {31'b0, rdy[2]}, 32'd0);
            chk($sformatf("vec%0d_adv_res", i), res[2], vt[i].exp);
        end
        last = vt[9].exp;
        // flush in the fourth BUSY cycle
        start(2, MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (4) tick();
        fls[2] = 1'b1;
        tick();
        fls[2] = 1'b0;
        mlt[2] = 1'b0;
        chk("flush_busy_rdy", {31'b0, rdy[2]}, 32'd0);
        chk("flush_busy_res", res[2], last);
        idle_watch(2, 12, "flush_busy_no_ready");
        // flush together with advance in DONE
        start(2, MUL, 32'd3, 32'd5);
        run_to_ready(2, lat);
        chk("fa_result", res[2], 32'd15);
        fls[2] = 1'b1;
        adv[2] = 1'b1;
        tick();
        fls[2] = 1'b0;
        adv[2] = 1'b0;
        mlt[2] = 1'b0;
        chk("fa_rdy", {31'b0, rdy[2]}, 32'd0);
        chk("fa_res", res[2], 32'd15);
        idle_watch(2, 4, "fa_no_ready");
        // back-to-back: second multiply accepted in the cycle after advance
        start(2, MUL, 32'd3, 32'd5);
        run_to_ready(2, lat);
        chk("b2b_first_lat", lat, 32'd9);
        chk("b2b_first_res", res[2], 32'd15);
        adv[2] = 1'b1;
        start(2, MUL, 32'h0001_0000, 32'h0001_0000);
        tick();
        adv[2] = 1'b0;
        chk("b2b_gap_rdy", {31'b0, rdy[2]}, 32'd0);
        run_to_ready(2, lat);
        chk("b2b_second_lat", lat, 32'd9);
        chk("b2b_second_res", res[2], 32'd0);
        mlt[2] = 1'b0;
        adv[2] = 1'b1;
        tick();
        adv[2] = 1'b0;
        idle_watch(2, 12, "b2b_no_extra_ready");
        // mult withdrawn while BUSY abandons the operation
        start(2, MUL, 32'd9, 32'd9);
        repeat (2) tick();
        mlt[2] = 1'b0;
        idle_watch(2, 12, "drop_no_ready");
        chk("drop_res", res[2], 32'd0);
        // reset in the middle of an operation
        start(2, MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mlt[2] = 1'b0;
        chk("rst_mid_res", res[2], 32'd0);
        chk("rst_mid_rdy", {31'b0, rdy[2]}, 32'd0);
        idle_watch(2, 12, "rst_mid_no_ready");
        start(2, MULH, 32'hFFFF_FFFE, 32'd3);
        run_to_ready(2, lat);
        chk("post_rst_res", res[2], 32'hFFFF_FFFF);
        mlt[2] = 1'b0;
        adv[2] = 1'b1;
        tick();
        adv[2] = 1'b0;
        for (int g = 0; g < 4; g++) run_random(g, 400);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
